// File: rtl/el2_exu_mul_wb_ctl.sv
// Writeback tracker/buffer behind the multiplier: shadow tag pipeline plus a small result FIFO.
// Optional combinational bypass of an empty FIFO when EL2_MUL_WB_BYPASS_EN is defined.
module el2_exu_mul_wb_ctl #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        flush,
  input  logic [31:0] result_x,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        busy
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  logic [LATENCY-1:0] sh_valid;
  logic [4:0]         sh_rd [LATENCY];
  wb_entry_t          fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic             fifo_empty, retire, bypass, push, pop, pop_fifo, accept;
  logic [OCC_W-1:0] occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every variable gets a default before any conditional update so no latch is inferred.
  always_comb begin
    occ = OCC_W'(count);
    for (int i = 0; i < LATENCY; i++) occ = occ + OCC_W'(sh_valid[i]);
  end

  assign fifo_empty = (count == '0);
  // A retire coinciding with flush is discarded; rd==0 results are dropped.
  assign retire     = sh_valid[LATENCY-1] & ~flush & (sh_rd[LATENCY-1] != 5'd0);

`ifdef EL2_MUL_WB_BYPASS_EN
  assign bypass = retire & fifo_empty & wb_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push        = retire & ~bypass;
  assign wb_valid    = ~fifo_empty | bypass;
  assign pop         = wb_valid & wb_ready;
  assign pop_fifo    = ~fifo_empty & wb_ready;
  assign issue_ready = ~flush & ((occ - OCC_W'(pop)) < OCC_W'(DEPTH));
  assign accept      = issue_valid & issue_ready;
  assign busy        = (occ != '0);

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (!fifo_empty) begin
      wb_rd   = fifo_mem[rd_ptr].rd;
      wb_data = fifo_mem[rd_ptr].data;
    end
`ifdef EL2_MUL_WB_BYPASS_EN
    else if (bypass) begin
      wb_rd   = sh_rd[LATENCY-1];
      wb_data = result_x;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sh_valid <= '0;
      for (int i = 0; i < LATENCY; i++) sh_rd[i] <= '0;
    end else begin
      sh_valid[0] <= accept;
      sh_rd[0]    <= issue_rd;
      for (int i = 1; i < LATENCY; i++) begin
        sh_valid[i] <= sh_valid[i-1] & ~flush;
        sh_rd[i]    <= sh_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (pop_fifo) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates visibility and outputs are zeroed when empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: sh_rd[LATENCY-1], data: result_x};
  end

  // Issue throttling guarantees a free slot for every completing result.
  assert property (@(posedge clk) disable iff (!rst_l)
    !(push && (count == CNT_W'(DEPTH)) && !pop_fifo));

endmodule

// File: tb/tb_el2_exu_mul_wb_ctl.sv
// Self-checking bench for el2_exu_mul_wb_ctl: directed scenarios plus random traffic
// compared each cycle against a queue-based model of ops in flight and results waiting.
module tb_el2_exu_mul_wb_ctl;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;
  logic [31:0] result_x;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        busy;

  el2_exu_mul_wb_ctl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .flush(flush), .result_x(result_x),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; int due; } op_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  op_t        inflight[$];
  wb_t        wbq[$];
  logic [4:0] wb_log[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         accepted;
  bit         last_wb_valid;
  bit         last_busy;
  logic [31:0] last_wb_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already driven; compare at the negedge, then advance the model.
  task automatic tick();
    bit          retiring, live, byp, pop, exp_valid, exp_ready;
    logic [4:0]  ret_rd, exp_rd;
    logic [31:0] exp_data;
    int          occ;
    @(negedge clk);
    retiring = (inflight.size() != 0) && (inflight[0].due == cyc);
    ret_rd   = retiring ? inflight[0].rd : 5'd0;
    live     = retiring && !flush;
    byp      = 1'b0;
`ifdef EL2_MUL_WB_BYPASS_EN
    byp = live && (ret_rd != 5'd0) && (wbq.size() == 0) && wb_ready;
`endif
    exp_valid = (wbq.size() != 0) || byp;
    exp_rd    = 5'd0;
    exp_data  = 32'd0;
    if (wbq.size() != 0) begin
      exp_rd   = wbq[0].rd;
      exp_data = wbq[0].data;
    end else if (byp) begin
      exp_rd   = ret_rd;
      exp_data = result_x;
    end
    occ       = wbq.size() + inflight.size();
    pop       = exp_valid && wb_ready;
    exp_ready = !flush && ((occ - int'(pop)) < DEPTH);

    check("issue_ready", 32'(issue_ready), 32'(exp_ready));
    check("wb_valid",    32'(wb_valid),    32'(exp_valid));
    check("wb_rd",       32'(wb_rd),       32'(exp_rd));
    check("wb_data",     wb_data,          exp_data);
    check("busy",        32'(busy),        32'(occ != 0));

    last_wb_valid = wb_valid;
    last_wb_data  = wb_data;
    last_busy     = busy;
    if (wb_valid && wb_ready) wb_log.push_back(wb_rd);

    if (pop && !byp) void'(wbq.pop_front());
    if (live && (ret_rd != 5'd0) && !byp) wbq.push_back('{ret_rd, result_x});
    if (retiring) void'(inflight.pop_front());
    if (flush) inflight.delete();
    accepted = issue_valid && exp_ready;
    if (accepted) inflight.push_back('{issue_rd, cyc + LATENCY});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    flush       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
    check({tag, "_wb_valid"},    32'(wb_valid),    32'd0);
    check({tag, "_wb_rd"},       32'(wb_rd),       32'd0);
    check({tag, "_wb_data"},     wb_data,          32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, away from any clock edge.
  task automatic async_reset();
    idle_inputs();
    #2 rst_l = 1'b0;
    #1 check_reset_outputs("rst_async");
    inflight.delete();
    wbq.delete();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int idx;
  int n;
  int hits;

  initial begin
    rst_l    = 1'b0;
    wb_ready = 1'b0;
    result_x = 32'd0;
    idle_inputs();
    #1 check_reset_outputs("rst_init");
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // 1: idle after reset
    repeat (3) tick();

    // 2: single op rd=5, result 6, measure issue-to-writeback latency
    wb_ready    = 1'b1;
    result_x    = 32'd6;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    check("t2_accept", 32'(accepted), 32'd1);
    idle_inputs();
    n = 1;
    while (n <= 10) begin
      tick();
      if (last_wb_valid) break;
      n++;
    end
`ifdef EL2_MUL_WB_BYPASS_EN
    check("t2_latency", n, LATENCY);
`else
    check("t2_latency", n, LATENCY + 1);
`endif
    check("t2_data", last_wb_data, 32'd6);
    repeat (3) tick();
    check("t2_busy_after", 32'(last_busy), 32'd0);

    // 3: back-to-back rd=1,2,3 with writeback stalled, then drain in order
    wb_log.delete();
    wb_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 40; t++) begin
      issue_valid = (idx < 3);
      issue_rd    = 5'(idx + 1);
      wb_ready    = (t >= 8);
      result_x    = $urandom;
      tick();
      if (accepted) idx++;
    end
    idle_inputs();
    check("t3_all_accepted", idx, 3);
    check("t3_wb_count", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      check("t3_order0", 32'(wb_log[0]), 32'd1);
      check("t3_order1", 32'(wb_log[1]), 32'd2);
      check("t3_order2", 32'(wb_log[2]), 32'd3);
    end

    // 4: rd=4 queued, rd=7 flushed one cycle before it retires
    wb_log.delete();
    wb_ready    = 1'b0;
    result_x    = 32'h4444_0004;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    tick();
    idle_inputs();
    repeat (LATENCY + 1) tick();
    result_x    = 32'h7777_0007;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    check("t4_accept7", 32'(accepted), 32'd1);
    idle_inputs();
    repeat (LATENCY - 2) tick();
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    wb_ready = 1'b1;
    repeat (LATENCY + 4) tick();
    hits = 0;
    foreach (wb_log[i]) if (wb_log[i] == 5'd7) hits++;
    check("t4_no_rd7", hits, 0);
    hits = 0;
    foreach (wb_log[i]) if (wb_log[i] == 5'd4) hits++;
    check("t4_rd4_once", hits, 1);
    check("t4_busy_after", 32'(last_busy), 32'd0);

    // 5: rd=0 op never writes back
    wb_log.delete();
    result_x    = 32'hDEAD_BEEF;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    idle_inputs();
    repeat (LATENCY + 1) tick();
    check("t5_no_wb", wb_log.size(), 0);
    check("t5_busy_after", 32'(last_busy), 32'd0);

    // 6: reset with ops queued and in flight
    wb_log.delete();
    wb_ready    = 1'b0;
    result_x    = 32'h0909_0909;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    idle_inputs();
    repeat (LATENCY) tick();
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    tick();
    idle_inputs();
    tick();
    check("t6_busy_before", 32'(last_busy), 32'd1);
    async_reset();
    wb_ready = 1'b1;
    repeat (LATENCY + 4) tick();
    check("t6_no_wb_after", wb_log.size(), 0);

    // Random traffic
    for (int t = 0; t < 2000; t++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      flush       = ($urandom_range(0, 15) == 0);
      wb_ready    = ($urandom_range(0, 9) < 6);
      result_x    = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
